// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and width helpers for the cache line-fill arbiter and its round-robin picker.
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fill_state_e;

  // Byte offset bits within one line.
  function automatic int unsigned off_width(input int unsigned words_per_line,
                                            input int unsigned word_bytes);
    return $clog2(words_per_line * word_bytes);
  endfunction

  // Word index bits within one line.
  function automatic int unsigned idx_width(input int unsigned words_per_line);
    return (words_per_line <= 1) ? 1 : $clog2(words_per_line);
  endfunction

  // Channel index bits; never below one so single-channel builds still have a port.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first requester after the last accepted grant.
module rr_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic                           i_accept,
  output logic                           o_valid,
  output logic [ch_width(NUM_REQ)-1:0]   o_grant
);

  localparam int unsigned IDX_W = ch_width(NUM_REQ);

  logic [IDX_W-1:0] r_last;
  int unsigned      w_idx;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_idx = int'(r_last) + off;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!o_valid && i_req[IDX_W'(w_idx)]) begin
        o_valid = 1'b1;
        o_grant = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IDX_W'(NUM_REQ - 1);
    end else if (i_accept && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Line-fill arbiter: round-robin grants one cache channel, streams a full line of reads
// to a pipelined memory and steers the returning words into that channel's arrays.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned WORD_BYTES     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH-1:0]                      miss,
  input  logic [NUM_CH*ADDR_W-1:0]               miss_addr,
  input  logic                                   mem_data_valid,
  output logic                                   mem_en,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [NUM_CH-1:0]                      stall,
  output logic [NUM_CH-1:0]                      write_data_array,
  output logic [NUM_CH-1:0]                      write_tag_array,
  output logic [idx_width(WORDS_PER_LINE)-1:0]   fill_word_idx,
  output logic [ch_width(NUM_CH)-1:0]            fill_ch,
  output logic                                   fill_busy
);

  localparam int unsigned OFF_W = off_width(WORDS_PER_LINE, WORD_BYTES);
  localparam int unsigned IDX_W = idx_width(WORDS_PER_LINE);
  localparam int unsigned CH_W  = ch_width(NUM_CH);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_LINE - 1);

  fill_state_e       r_state;
  logic [IDX_W-1:0]  r_issue_cnt;
  logic [IDX_W-1:0]  r_recv_cnt;
  logic [CH_W-1:0]   r_fill_ch;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_fill_busy;

  logic              w_req_valid;
  logic [CH_W-1:0]   w_grant;
  logic [ADDR_W-1:0] w_miss_sel;
  logic [ADDR_W-1:0] w_base;
  logic              w_accept;
  logic              w_recv;
  logic              w_last_recv;

  assign w_accept = (r_state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_CH)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (miss),
    .i_accept (w_accept),
    .o_valid  (w_req_valid),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_miss_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant == CH_W'(i)) begin
        w_miss_sel = miss_addr[i*ADDR_W +: ADDR_W];
      end
    end
    w_base = w_miss_sel & LINE_MASK;
  end

  // mem_addr is stepped incrementally rather than rebuilt from base + issue_cnt*WORD_BYTES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_fill_ch   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_fill_busy <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_valid) begin
            r_state     <= ISSUE;
            r_fill_ch   <= w_grant;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= w_base;
            r_fill_busy <= 1'b1;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        ISSUE, DRAIN: begin
          if (r_state == ISSUE) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_issue_cnt == LAST_WORD) begin
              r_mem_en <= 1'b0;
              r_state  <= DRAIN;
            end else begin
              r_mem_addr <= r_mem_addr + WORD_STEP;
            end
          end
          if (mem_data_valid) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
            if (r_recv_cnt == LAST_WORD) begin
              r_state     <= IDLE;
              r_mem_en    <= 1'b0;
              r_fill_busy <= 1'b0;
              r_issue_cnt <= '0;
              r_recv_cnt  <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_recv      = r_fill_busy && mem_data_valid;
  assign w_last_recv = w_recv && (r_recv_cnt == LAST_WORD);

  always_comb begin
    write_data_array = '0;
    write_tag_array  = '0;
    stall            = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      write_data_array[i] = w_recv && (r_fill_ch == CH_W'(i));
      write_tag_array[i]  = w_last_recv && (r_fill_ch == CH_W'(i));
      stall[i]            = miss[i] | (r_fill_busy && (r_fill_ch == CH_W'(i)));
    end
  end

  assign mem_en        = r_mem_en;
  assign mem_addr      = r_mem_addr;
  assign fill_word_idx = r_recv_cnt;
  assign fill_ch       = r_fill_ch;
  assign fill_busy     = r_fill_busy;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter against a latency-4 pipelined memory model.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default build: 2 channels, 8 words/line.
  logic [1:0]  a_miss;
  logic [31:0] a_miss_addr;
  logic        a_valid;
  logic        a_pulse;
  logic [3:0]  a_pipe;
  logic        a_mem_en;
  logic [15:0] a_mem_addr;
  logic [1:0]  a_stall;
  logic [1:0]  a_wda;
  logic [1:0]  a_wta;
  logic [2:0]  a_idx;
  logic        a_ch;
  logic        a_busy;

  // Narrow build: 3 channels, 4 words/line.
  logic [2:0]  b_miss;
  logic [47:0] b_miss_addr;
  logic        b_valid;
  logic [3:0]  b_pipe;
  logic        b_mem_en;
  logic [15:0] b_mem_addr;
  logic [2:0]  b_stall;
  logic [2:0]  b_wda;
  logic [2:0]  b_wta;
  logic [1:0]  b_idx;
  logic [1:0]  b_ch;
  logic        b_busy;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  assign a_valid = a_pipe[3] | a_pulse;
  assign b_valid = b_pipe[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe <= {a_pipe[2:0], a_mem_en};
      b_pipe <= {b_pipe[2:0], b_mem_en};
    end
  end

  cache_fill_arbiter u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .miss             (a_miss),
    .miss_addr        (a_miss_addr),
    .mem_data_valid   (a_valid),
    .mem_en           (a_mem_en),
    .mem_addr         (a_mem_addr),
    .stall            (a_stall),
    .write_data_array (a_wda),
    .write_tag_array  (a_wta),
    .fill_word_idx    (a_idx),
    .fill_ch          (a_ch),
    .fill_busy        (a_busy)
  );

  cache_fill_arbiter #(
    .NUM_CH         (3),
    .ADDR_W         (16),
    .WORDS_PER_LINE (4),
    .WORD_BYTES     (2)
  ) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .miss             (b_miss),
    .miss_addr        (b_miss_addr),
    .mem_data_valid   (b_valid),
    .mem_en           (b_mem_en),
    .mem_addr         (b_mem_addr),
    .stall            (b_stall),
    .write_data_array (b_wda),
    .write_tag_array  (b_wta),
    .fill_word_idx    (b_idx),
    .fill_ch          (b_ch),
    .fill_busy        (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Caller has presented the miss in cycle 0; this walks cycles 1..13 of one fill on DUT A.
  task automatic watch_fill_a(input int ch, input logic [15:0] base,
                              input logic [1:0] m3, input logic [1:0] m13);
    logic [1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      cyc_no = c;
      if (c == 3)  a_miss = m3;
      if (c == 13) a_miss = m13;
      #1;
      chk("a_mem_en", 32'(a_mem_en), 32'(c <= 8));
      if (c <= 8) chk("a_mem_addr", 32'(a_mem_addr), 32'(16'(base + 16'(2 * (c - 1)))));
      chk("a_fill_busy", 32'(a_busy), 32'(c <= 12));
      chk("a_wda", 32'(a_wda), (c >= 5 && c <= 12) ? 32'(oh) : 32'd0);
      chk("a_wta", 32'(a_wta), (c == 12) ? 32'(oh) : 32'd0);
      if (c >= 5 && c <= 12) chk("a_idx", 32'(a_idx), 32'(c - 5));
      if (c <= 12) chk("a_fill_ch", 32'(a_ch), 32'(ch));
      chk("a_stall", 32'(a_stall), 32'(a_miss | ((c <= 12) ? oh : 2'b00)));
    end
  endtask

  initial begin
    rst         = 1'b0;
    a_miss      = 2'b10;
    a_miss_addr = '0;
    a_pulse     = 1'b0;
    b_miss      = '0;
    b_miss_addr = '0;

    // Reset state; stall follows miss even while held in reset.
    #12;
    chk("rst_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_fill_ch", 32'(a_ch), 32'd0);
    chk("rst_idx", 32'(a_idx), 32'd0);
    chk("rst_wda", 32'(a_wda), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'b10);
    a_miss = 2'b00;
    #1;
    chk("rst_stall_off", 32'(a_stall), 32'b00);
    cyc();
    rst = 1'b1;
    cyc();

    // Single miss on ch0 at 0x1234.
    a_miss_addr = {16'h0000, 16'h1234};
    a_miss      = 2'b01;
    #1;
    watch_fill_a(0, 16'h1230, 2'b01, 2'b00);

    // Fresh reset, then simultaneous misses; then ch1 alone; then both with ch1 last served.
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    a_miss_addr = {16'h2000, 16'h0100};
    a_miss      = 2'b11;
    #1;
    watch_fill_a(0, 16'h0100, 2'b11, 2'b10);
    watch_fill_a(1, 16'h2000, 2'b10, 2'b10);
    watch_fill_a(1, 16'h2000, 2'b10, 2'b11);
    watch_fill_a(0, 16'h0100, 2'b11, 2'b00);

    // Stray valid in IDLE is dropped.
    cyc();
    cyc_no  = 100;
    a_pulse = 1'b1;
    #1;
    chk("idle_wda", 32'(a_wda), 32'd0);
    chk("idle_wta", 32'(a_wta), 32'd0);
    chk("idle_busy", 32'(a_busy), 32'd0);
    cyc();
    cyc_no  = 101;
    a_pulse = 1'b0;
    #1;
    chk("idle_busy2", 32'(a_busy), 32'd0);
    chk("idle_mem_en2", 32'(a_mem_en), 32'd0);
    chk("idle_idx2", 32'(a_idx), 32'd0);

    // Reset in cycle 6 of a ch1 fill, then restart from the first word.
    a_miss_addr = {16'h2004, 16'h0000};
    a_miss      = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      cyc();
    end
    cyc();
    cyc_no = 206;
    rst    = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(a_mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_wda", 32'(a_wda), 32'd0);
    chk("mid_rst_wta", 32'(a_wta), 32'd0);
    chk("mid_rst_fill_ch", 32'(a_ch), 32'd0);
    chk("mid_rst_idx", 32'(a_idx), 32'd0);
    chk("mid_rst_stall", 32'(a_stall), 32'b10);
    cyc();
    rst = 1'b1;
    #1;
    chk("post_rst_busy", 32'(a_busy), 32'd0);
    watch_fill_a(1, 16'h2000, 2'b10, 2'b00);

    // Miss withdrawn in cycle 3: line still completes on ch0.
    a_miss_addr = {16'h0000, 16'h4446};
    a_miss      = 2'b01;
    #1;
    watch_fill_a(0, 16'h4440, 2'b00, 2'b00);

    // Three-channel, 4-word build: ch2 at 0xFFFA.
    b_miss_addr = {16'hFFFA, 16'h0000, 16'h0000};
    b_miss      = 3'b100;
    #1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      cyc_no = 300 + c;
      if (c == 9) b_miss = 3'b000;
      #1;
      chk("b_mem_en", 32'(b_mem_en), 32'(c <= 4));
      if (c <= 4) chk("b_mem_addr", 32'(b_mem_addr), 32'(16'(16'hFFF8 + 16'(2 * (c - 1)))));
      chk("b_busy", 32'(b_busy), 32'(c <= 8));
      chk("b_wda", 32'(b_wda), (c >= 5 && c <= 8) ? 32'b100 : 32'd0);
      chk("b_wta", 32'(b_wta), (c == 8) ? 32'b100 : 32'd0);
      if (c >= 5 && c <= 8) chk("b_idx", 32'(b_idx), 32'(c - 5));
      if (c <= 8) chk("b_fill_ch", 32'(b_ch), 32'd2);
      chk("b_stall", 32'(b_stall), 32'(b_miss | ((c <= 8) ? 3'b100 : 3'b000)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
